seg7_scan_out: RTL and testbench

//  Multiplexed 7-segment display driver: the human-facing output end of the board I/O path.

---
 rtl/seg7_scan_out_if.sv | 24 ++
 rtl/seg7_scan_out.sv | 138 +++++++++++++
 tb/tb_seg7_scan_out.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_out_if.sv
// Bus bundle for seg7_scan_out: load strobe/data in, scan outputs and acknowledge back.
// The display driver takes the slave modport; the data source takes master.
interface seg7_scan_out_if #(
    parameter int NDIG = 4
);
    logic                LOAD;
    logic [4*NDIG-1:0]   DIN;
    logic [NDIG-1:0]     DPIN;
    logic                LACK;
    logic                FRAME;
    logic [6:0]          nSEG;
    logic                nDP;
    logic [NDIG-1:0]     nDIG;

    modport master (
        output LOAD, DIN, DPIN,
        input  LACK, FRAME, nSEG, nDP, nDIG
    );

    modport slave (
        input  LOAD, DIN, DPIN,
        output LACK, FRAME, nSEG, nDP, nDIG
    );
endinterface

// File: rtl/seg7_scan_out.sv
// Multiplexed common-anode 7-segment driver with frame-aligned data update and blanking.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_out #(
    parameter int DIV   = 50000,
    parameter int NDIG  = 4,
    parameter int BLANK = 500
) (
    input  logic              CLK,
    input  logic              RST,
    seg7_scan_out_if.slave    bus
);

    localparam int CW = $clog2(DIV);
    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [CW-1:0]       r_cnt;
    logic [DW-1:0]       r_dig;
    logic [4*NDIG-1:0]   r_shadow;
    logic [NDIG-1:0]     r_shadow_dp;
    logic                r_pend;
    logic [4*NDIG-1:0]   r_act;
    logic [NDIG-1:0]     r_dp_act;

    logic                r_lack;
    logic                r_frame;
    logic [6:0]          r_nseg;
    logic                r_ndp;
    logic [NDIG-1:0]     r_ndig;

    logic                w_tick;
    logic                w_bound;
    logic                w_blank_ph;
    logic [3:0]          w_nib;
    logic [6:0]          w_seg;
    logic [NDIG-1:0]     w_ndig;
    logic [NDIG-1:0]     w_lz;

    function automatic logic [6:0] f_dec(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_tick  = (r_cnt == CW'(DIV - 1));
    assign w_bound = w_tick && (r_dig == DW'(NDIG - 1));
    assign w_nib   = r_act[4*int'(r_dig) +: 4];

    generate
        if (BLANK == 0) begin : g_noblank
            assign w_blank_ph = 1'b0;
        end else begin : g_blank
            assign w_blank_ph = (r_cnt < CW'(BLANK));
        end
    endgenerate

    always_comb begin
        w_ndig = '1;
        if (!w_blank_ph)
            w_ndig[r_dig] = 1'b0;
    end

`ifdef SEG7_LZB_EN
    // w_lz[i] set when digit i and every digit above it are zero; digit 0 always shown
    always_comb begin : lzb_mask
        logic v_all_zero;
        v_all_zero = 1'b1;
        w_lz       = '0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            v_all_zero = v_all_zero & (r_act[4*i +: 4] == 4'h0);
            w_lz[i]    = v_all_zero;
        end
    end
    assign w_seg = w_lz[r_dig] ? 7'h7F : f_dec(w_nib);
`else
    assign w_lz  = '0;
    assign w_seg = f_dec(w_nib);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt       <= '0;
            r_dig       <= '0;
            r_shadow    <= '0;
            r_shadow_dp <= '0;
            r_pend      <= 1'b0;
            r_act       <= '0;
            r_dp_act    <= '0;
            r_lack      <= 1'b0;
            r_frame     <= 1'b0;
            r_nseg      <= 7'h7F;
            r_ndp       <= 1'b1;
            r_ndig      <= '1;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick)
                r_dig <= (r_dig == DW'(NDIG - 1)) ? '0 : r_dig + 1'b1;

            r_frame <= w_bound;
            r_lack  <= 1'b0;

            // A LOAD coinciding with the boundary bypasses the shadow so it is not delayed a frame
            if (w_bound) begin
                if (bus.LOAD) begin
                    r_act    <= bus.DIN;
                    r_dp_act <= bus.DPIN;
                    r_pend   <= 1'b0;
                    r_lack   <= 1'b1;
                end else if (r_pend) begin
                    r_act    <= r_shadow;
                    r_dp_act <= r_shadow_dp;
                    r_pend   <= 1'b0;
                    r_lack   <= 1'b1;
                end
            end else if (bus.LOAD) begin
                r_shadow    <= bus.DIN;
                r_shadow_dp <= bus.DPIN;
                r_pend      <= 1'b1;
            end

            r_nseg <= w_seg;
            r_ndp  <= ~r_dp_act[r_dig];
            r_ndig <= w_ndig;
        end
    end

    assign bus.LACK  = r_lack;
    assign bus.FRAME = r_frame;
    assign bus.nSEG  = r_nseg;
    assign bus.nDP   = r_ndp;
    assign bus.nDIG  = r_ndig;

endmodule

// File: tb/tb_seg7_scan_out.sv
// Bench for seg7_scan_out: directed scenarios then random LOAD/RST traffic,
// compared each cycle against a time-based model of the scan and data update.
module tb_seg7_scan_out;

    localparam int DIV   = 8;
    localparam int NDIG  = 4;
    localparam int BLANK = 2;
    localparam int FRAME_LEN = DIV * NDIG;

    logic CLK = 1'b0;
    logic RST;

    seg7_scan_out_if #(.NDIG(NDIG)) bus ();

    seg7_scan_out #(.DIV(DIV), .NDIG(NDIG), .BLANK(BLANK)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // model state: m_t counts cycles since reset release
    int          m_t;
    logic [15:0] m_act, m_sh;
    logic [3:0]  m_dp, m_shdp;
    bit          m_pend;
    bit          m_valid = 0;

    logic [6:0]  e_seg;
    logic        e_dp, e_lack, e_frame;
    logic [3:0]  e_dig;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit ld, input logic [15:0] d, input logic [3:0] dp);
        int  phase, dg;
        bit  bound, lz;
        logic [3:0] nib;
        @(negedge CLK);
        if (m_valid) begin
            check("nDIG", 32'(bus.nDIG), 32'(e_dig));
            check("LACK", 32'(bus.LACK), 32'(e_lack));
            check("FRAME", 32'(bus.FRAME), 32'(e_frame));
            if (e_dig != 4'hF) begin
                check("nSEG", 32'(bus.nSEG), 32'(e_seg));
                check("nDP", 32'(bus.nDP), 32'(e_dp));
            end
        end
        RST      = rst;
        bus.LOAD = ld;
        bus.DIN  = d;
        bus.DPIN = dp;
        if (rst) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF; e_lack = 1'b0; e_frame = 1'b0;
            m_t = 0; m_act = '0; m_sh = '0; m_dp = '0; m_shdp = '0; m_pend = 0;
        end else begin
            phase = m_t % DIV;
            dg    = (m_t / DIV) % NDIG;
            bound = (m_t % FRAME_LEN) == FRAME_LEN - 1;
            nib   = 4'((m_act >> (4 * dg)) & 16'hF);
`ifdef SEG7_LZB_EN
            lz = (dg != 0) && ((m_act >> (4 * dg)) == 16'h0);
`else
            lz = 0;
`endif
            e_seg   = lz ? 7'h7F : seg_tbl[nib];
            e_dp    = ~m_dp[dg];
            e_dig   = (phase < BLANK) ? 4'hF : ~(4'(1) << dg);
            e_frame = bound;
            e_lack  = bound && (ld || m_pend);
            if (bound) begin
                if (ld) begin
                    m_act = d; m_dp = dp;
                end else if (m_pend) begin
                    m_act = m_sh; m_dp = m_shdp;
                end
                m_pend = 0;
            end else if (ld) begin
                m_sh = d; m_shdp = dp; m_pend = 1;
            end
            m_t++;
        end
        m_valid = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 4'h0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 16'h0, 4'h0);
    endtask

    initial begin
        RST      = 1'b1;
        bus.LOAD = 1'b0;
        bus.DIN  = '0;
        bus.DPIN = '0;

        do_reset(3);
        idle(2 * FRAME_LEN + 4);

        do_reset(2);
        idle(5);
        step(0, 1, 16'hF810, 4'b0100);
        idle(2 * FRAME_LEN);

        do_reset(1);
        idle(5);
        step(0, 1, 16'h1111, 4'h0);
        idle(14);
        step(0, 1, 16'h2222, 4'h0);
        idle(2 * FRAME_LEN);

        while ((m_t % FRAME_LEN) != FRAME_LEN - 1) idle(1);
        step(0, 1, 16'h3333, 4'b1001);
        idle(2 * FRAME_LEN);

        do_reset(1);
        idle(5);
        step(0, 1, 16'h9ABC, 4'hF);
        idle(4);
        do_reset(2);
        idle(2 * FRAME_LEN);

        step(0, 1, 16'h0050, 4'b0010);
        idle(2 * FRAME_LEN);
        step(0, 1, 16'h0000, 4'h0);
        idle(2 * FRAME_LEN);

        for (int i = 0; i < 2500; i++) begin
            bit          r, l;
            logic [15:0] d;
            logic [3:0]  p;
            r = ($urandom % 400) == 0;
            l = ($urandom % 12) == 0;
            d = 16'($urandom);
            if (($urandom % 4) == 0) d = d & 16'h00FF;
            p = 4'($urandom);
            step(r, l, d, p);
        end
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
